display_panel_receiver: RTL and testbench
=========================================

DISPLAY_PANEL_RECEIVER -- requirements
Module: display_panel_receiver

Interface
REQ-001 Parameter segments, default 1: number of parallel RGB segments.
REQ-002 Parameter rows, default 8: number of addressable rows.
REQ-003 Parameter columns, default 32: shifted bits per line.
REQ-004 Parameter width_bits, default 16: width of the oe pulse-width counter.
REQ-005 clk  in  1  single clock.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 rgb  in  3*segments  panel serial data, sampled in the clk domain.
REQ-008 oclk  in  1  panel shift clock, oversampled.
REQ-009 lat  in  1  panel latch strobe.
REQ-010 oe  in  1  panel output enable, active-high.
REQ-011 row  in  $clog2(rows)  panel row address.
REQ-012 out_valid  out  1  column record valid.
REQ-013 out_ready  in  1  consumer accepts record.
REQ-014 out_row, out_column, out_rgb, out_width  out  $clog2(rows)/$clog2(columns)/3*segments/width_bits  record fields.
REQ-015 out_last  out  1  marks the final column of a pulse.
REQ-016 err_count, err_overrun  out  1/1  sticky error flags.

Function
REQ-017 The block SHALL register rgb, oclk, lat, oe and row once; the first-stage values SHALL be compared against a second registered copy for edge detection.
REQ-018 On each detected oclk rise, the registered rgb SHALL be stored at the capture index k, and k SHALL increment; k saturates at columns.
REQ-019 On a detected lat rise, the capture buffer SHALL copy to the latch buffer, and k SHALL clear to 0.
REQ-020 On a lat rise with k != columns, err_count SHALL set.
REQ-021 FSM states: IDLE, PULSE, DRAIN; reset state IDLE.
REQ-022 IDLE->PULSE on registered oe high; the width counter SHALL load 1 and the registered row SHALL be captured.
REQ-023 In PULSE, the width counter SHALL increment each cycle oe stays high, saturating at all-ones.
REQ-024 PULSE->DRAIN on the registered oe falling; the latch buffer SHALL be snapshotted into the drain buffer.
REQ-025 In DRAIN, records SHALL emit for columns 0..columns-1 in order.
  - out_rgb = drain buffer entry; out_width and out_row = captured values.
  - out_last high on column columns-1.
REQ-026 A record SHALL advance only when out_valid && out_ready; out_* SHALL hold stable while out_valid && !out_ready.
REQ-027 DRAIN->IDLE after the out_last handshake; out_valid SHALL drop in the following cycle unless a new pulse is pending.
REQ-028 If oe rises while in DRAIN, err_overrun SHALL set and that pulse SHALL be discarded (no record, no width).
REQ-029 Capture and latch (REQ-018/019) SHALL continue in every FSM state, independent of DRAIN backpressure.
REQ-030 Simultaneous oclk rise and lat rise: the bit SHALL be captured first, then the latch SHALL copy including that bit.
REQ-031 oe deassert to first out_valid SHALL be 2 clk cycles (registered-input stage plus FSM transition).

Reset
REQ-032 On rst: FSM=IDLE, k=0, width=0, out_valid=0, out_last=0, all out_* fields=0, err flags=0, buffers cleared.
REQ-033 rst asserted mid-DRAIN SHALL abort the record stream with no further out_valid.

Configuration
REQ-034 With DISPLAY_PANEL_RECEIVER_ERR_EN defined, REQ-020 and REQ-028 detection SHALL be compiled in; err flags SHALL clear only on rst.
REQ-035 Without DISPLAY_PANEL_RECEIVER_ERR_EN, err_count and err_overrun SHALL be tied 0; discard behaviour of REQ-028 SHALL remain.

Structure
REQ-036 The FSM state enumeration and record field-width constants SHALL live in a shared display package.
REQ-037 Shift/latch capture SHALL be one sub-module, display_panel_capture, with outputs latch buffer and count error.

Verification
REQ-038 Shift 32 columns of rgb=3'b101, lat, oe high 8 cycles, out_ready=1 -> 32 records, out_rgb=3'b101, out_width=8, out_last on column 31.
REQ-039 Shift only 30 columns, then lat -> err_count=1 (ERR_EN defined), 0 (undefined).
REQ-040 out_ready low 5 cycles mid-DRAIN at column 10 -> column 10 record held stable, no column skipped or repeated.
REQ-041 oe rises during DRAIN -> err_overrun=1, record count stays 32, next clean pulse emitted normally.
REQ-042 oe held high 70000 cycles, width_bits=16 -> out_width=16'hFFFF.
REQ-043 rst asserted at column 5 of DRAIN -> out_valid=0 the next cycle; all outputs at reset values.

Source files
------------

// File: rtl/display_panel_receiver_pkg.sv
// Shared definitions for the display panel receiver: FSM states and
// record field-width helpers used by the interface, capture and top.
package display_panel_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One R, G and B bit per parallel segment
  localparam int unsigned RGB_PER_SEG = 3;

  function automatic int unsigned rgb_bits(input int unsigned segs);
    return RGB_PER_SEG * segs;
  endfunction

  // Index width for n entries, never narrower than one bit
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display_panel_receiver_if.sv
// Panel-side inputs plus the column-record stream and error flags.
// master: panel driver / record consumer; slave: the receiver.
interface display_panel_receiver_if
  import display_panel_receiver_pkg::*;
#(
  parameter int unsigned segments   = 1,
  parameter int unsigned rows       = 8,
  parameter int unsigned columns    = 32,
  parameter int unsigned width_bits = 16
) ();

  logic [rgb_bits(segments)-1:0] rgb;
  logic                          oclk;
  logic                          lat;
  logic                          oe;
  logic [idx_bits(rows)-1:0]     row;

  logic                          out_valid;
  logic                          out_ready;
  logic [idx_bits(rows)-1:0]     out_row;
  logic [idx_bits(columns)-1:0]  out_column;
  logic [rgb_bits(segments)-1:0] out_rgb;
  logic [width_bits-1:0]         out_width;
  logic                          out_last;
  logic                          err_count;
  logic                          err_overrun;

  modport master (
    output rgb, oclk, lat, oe, row, out_ready,
    input  out_valid, out_row, out_column, out_rgb, out_width, out_last,
           err_count, err_overrun
  );

  modport slave (
    input  rgb, oclk, lat, oe, row, out_ready,
    output out_valid, out_row, out_column, out_rgb, out_width, out_last,
           err_count, err_overrun
  );

endinterface

// File: rtl/display_panel_receiver_capture.sv
// Shift/latch capture for the display panel receiver (module display_panel_capture).
// Stores rgb at index k on each shift strobe (k saturates at columns) and
// copies the line into the latch buffer on each latch strobe.
module display_panel_capture
  import display_panel_receiver_pkg::*;
#(
  parameter int unsigned columns = 32,
  parameter int unsigned rgb_w   = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [rgb_w-1:0]                i_rgb,
  input  logic                            i_shift,
  input  logic                            i_latch,
  output logic [columns-1:0][rgb_w-1:0]   o_latch_buf,
  output logic                            o_count_err
);

  localparam int unsigned K_W    = $clog2(columns + 1);
  localparam int unsigned COL_W  = idx_bits(columns);
  localparam logic [K_W-1:0] K_FULL = K_W'(columns);

  logic [K_W-1:0]                  r_k;
  logic [K_W-1:0]                  w_k_next;
  logic [columns-1:0][rgb_w-1:0]   r_cap;
  logic [columns-1:0][rgb_w-1:0]   w_cap_next;
  logic [columns-1:0][rgb_w-1:0]   r_latch;
  logic                            r_count_err;

  // Apply the shift first so a same-cycle latch copies the new bit too
  always_comb begin
    w_cap_next = r_cap;
    w_k_next   = r_k;
    if (i_shift && (r_k < K_FULL)) begin
      w_cap_next[r_k[COL_W-1:0]] = i_rgb;
      w_k_next                   = r_k + K_W'(1);
    end
  end

  // Capture buffer, index, latch copy and short-line detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_cap       <= '0;
      r_latch     <= '0;
      r_count_err <= 1'b0;
    end else begin
      r_cap       <= w_cap_next;
      r_k         <= i_latch ? '0 : w_k_next;
      r_count_err <= i_latch && (w_k_next != K_FULL);
      if (i_latch) begin
        r_latch <= w_cap_next;
      end
    end
  end

  assign o_latch_buf = r_latch;
  assign o_count_err = r_count_err;

endmodule

// File: rtl/display_panel_receiver.sv
// Display panel receiver: oversamples a HUB-style panel bus, measures each
// oe pulse and streams one record per column of the latched line.
// Optional: define DISPLAY_PANEL_RECEIVER_ERR_EN to enable the sticky
// err_count / err_overrun flags (otherwise they stay 0).
module display_panel_receiver
  import display_panel_receiver_pkg::*;
#(
  parameter int unsigned segments   = 1,
  parameter int unsigned rows       = 8,
  parameter int unsigned columns    = 32,
  parameter int unsigned width_bits = 16
) (
  input logic                     clk,
  input logic                     rst,
  display_panel_receiver_if.slave bus
);

  localparam int unsigned RGB_W = rgb_bits(segments);
  localparam int unsigned ROW_W = idx_bits(rows);
  localparam int unsigned COL_W = idx_bits(columns);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(columns - 1);
  localparam logic [width_bits-1:0] WIDTH_ONE = width_bits'(1);

`ifdef DISPLAY_PANEL_RECEIVER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic [RGB_W-1:0] r_rgb1;
  logic             r_oclk1, r_oclk2;
  logic             r_lat1, r_lat2;
  logic             r_oe1, r_oe2;
  logic [ROW_W-1:0] r_row1;

  logic w_oclk_rise, w_lat_rise, w_oe_rise, w_oe_fall;

  state_t r_state, w_state_next;

  logic [width_bits-1:0]         r_width;
  logic [ROW_W-1:0]              r_row_cap;
  logic [COL_W-1:0]              r_col;
  logic [columns-1:0][RGB_W-1:0] r_drain;
  logic [columns-1:0][RGB_W-1:0] w_latch_buf;
  logic                          w_count_err;
  logic                          r_discard;
  logic                          r_err_count, r_err_overrun;
  logic                          w_valid, w_fire;

  // Input register stage plus delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb1  <= '0;
      r_oclk1 <= 1'b0;
      r_oclk2 <= 1'b0;
      r_lat1  <= 1'b0;
      r_lat2  <= 1'b0;
      r_oe1   <= 1'b0;
      r_oe2   <= 1'b0;
      r_row1  <= '0;
    end else begin
      r_rgb1  <= bus.rgb;
      r_oclk1 <= bus.oclk;
      r_oclk2 <= r_oclk1;
      r_lat1  <= bus.lat;
      r_lat2  <= r_lat1;
      r_oe1   <= bus.oe;
      r_oe2   <= r_oe1;
      r_row1  <= bus.row;
    end
  end

  assign w_oclk_rise = r_oclk1 & ~r_oclk2;
  assign w_lat_rise  = r_lat1 & ~r_lat2;
  assign w_oe_rise   = r_oe1 & ~r_oe2;
  assign w_oe_fall   = ~r_oe1 & r_oe2;

  display_panel_capture #(
    .columns (columns),
    .rgb_w   (RGB_W)
  ) u_capture (
    .clk         (clk),
    .rst         (rst),
    .i_rgb       (r_rgb1),
    .i_shift     (w_oclk_rise),
    .i_latch     (w_lat_rise),
    .o_latch_buf (w_latch_buf),
    .o_count_err (w_count_err)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_next = r_state;
    w_valid      = 1'b0;
    w_fire       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_oe1 && !r_discard) begin
          w_state_next = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (w_oe_fall) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_valid = 1'b1;
        w_fire  = bus.out_ready;
        if (bus.out_ready && (r_col == COL_LAST)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Pulse measurement, drain snapshot and column sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_width   <= '0;
      r_row_cap <= '0;
      r_col     <= '0;
      r_drain   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_state_next == ST_PULSE) begin
            r_width   <= WIDTH_ONE;
            r_row_cap <= r_row1;
          end
        end
        ST_PULSE: begin
          if (r_oe1) begin
            if (r_width != '1) begin
              r_width <= r_width + WIDTH_ONE;
            end
          end else if (w_oe_fall) begin
            r_drain <= w_latch_buf;
            r_col   <= '0;
          end
        end
        ST_DRAIN: begin
          if (w_fire) begin
            r_col <= (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A pulse that starts during DRAIN is ignored until oe drops, so its
  // tail cannot be mistaken for a fresh pulse once the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_discard <= 1'b0;
    end else begin
      r_discard <= r_oe1 & (r_discard | ((r_state == ST_DRAIN) & w_oe_rise));
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (ERR_EN && w_count_err) begin
        r_err_count <= 1'b1;
      end
      if (ERR_EN && (r_state == ST_DRAIN) && w_oe_rise) begin
        r_err_overrun <= 1'b1;
      end
    end
  end

  assign bus.out_valid   = w_valid;
  assign bus.out_row     = r_row_cap;
  assign bus.out_column  = r_col;
  assign bus.out_rgb     = r_drain[r_col];
  assign bus.out_width   = r_width;
  assign bus.out_last    = w_valid && (r_col == COL_LAST);
  assign bus.err_count   = r_err_count;
  assign bus.err_overrun = r_err_overrun;

endmodule

// File: tb/tb_display_panel_receiver.sv
// Scoreboard bench for display_panel_receiver: a line/pulse-level model
// queues the expected column records, a monitor compares on every valid.
module tb_display_panel_receiver;
  import display_panel_receiver_pkg::*;

  localparam int unsigned SEGS  = 1;
  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 32;
  localparam int unsigned WB    = 16;
  localparam int unsigned RGB_W = rgb_bits(SEGS);
  localparam int unsigned ROW_W = idx_bits(ROWS);
  localparam int unsigned COL_W = idx_bits(COLS);
  localparam int unsigned WMAX  = (1 << WB) - 1;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [RGB_W-1:0] rgb;
    logic [WB-1:0]    width;
    logic             last;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_panel_receiver_if #(
    .segments(SEGS), .rows(ROWS), .columns(COLS), .width_bits(WB)
  ) bus ();

  display_panel_receiver #(
    .segments(SEGS), .rows(ROWS), .columns(COLS), .width_bits(WB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  rec_t exp_q[$];
  int n_pushed = 0;
  int n_recv   = 0;

  // Reference model of the panel line and flags
  logic [RGB_W-1:0] m_cap[COLS];
  logic [RGB_W-1:0] m_lat[COLS];
  int unsigned      m_k = 0;
  bit               m_err_count = 0;
  bit               m_err_overrun = 0;

  int ready_mode = 0;
  bit stall_done = 0;

  function automatic bit exp_flag(input bit f);
`ifdef DISPLAY_PANEL_RECEIVER_ERR_EN
    return f;
`else
    return 1'b0 & f;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < COLS; i++) begin
      m_cap[i] = '0;
      m_lat[i] = '0;
    end
    m_k = 0;
    m_err_count = 0;
    m_err_overrun = 0;
  endtask

  task automatic model_shift(input logic [RGB_W-1:0] v);
    if (m_k < COLS) begin
      m_cap[m_k] = v;
      m_k++;
    end
  endtask

  task automatic model_latch();
    for (int i = 0; i < COLS; i++) m_lat[i] = m_cap[i];
    if (m_k != COLS) m_err_count = 1;
    m_k = 0;
  endtask

  // Shift n columns; latch either with the last shift or afterwards
  task automatic shift_line(input int n, input bit lat_with_last,
                            input bit use_fixed, input logic [RGB_W-1:0] fixed);
    logic [RGB_W-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = use_fixed ? fixed : RGB_W'($urandom);
      bus.rgb  = v;
      bus.oclk = 1'b1;
      model_shift(v);
      if (lat_with_last && (i == n - 1)) begin
        bus.lat = 1'b1;
        model_latch();
      end
      tick();
      bus.oclk = 1'b0;
      bus.lat  = 1'b0;
      tick();
    end
    if (!lat_with_last) begin
      bus.lat = 1'b1;
      model_latch();
      tick();
      bus.lat = 1'b0;
      tick();
    end
  endtask

  // Drive oe high for w cycles; a kept pulse yields one record per column
  task automatic pulse(input logic [ROW_W-1:0] r, input int w, input bit keep);
    rec_t e;
    if (keep) begin
      for (int c = 0; c < COLS; c++) begin
        e.row   = r;
        e.col   = COL_W'(c);
        e.rgb   = m_lat[c];
        e.width = WB'((w > WMAX) ? WMAX : w);
        e.last  = (c == COLS - 1);
        exp_q.push_back(e);
        n_pushed++;
      end
    end
    bus.row = r;
    bus.oe  = 1'b1;
    repeat (w) @(posedge clk);
    #1;
    bus.oe = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (bus.out_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("wait_valid_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain(input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      if ((exp_q.size() == 0) && !bus.out_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("drain_timeout", 64'(ok), 64'd1);
    check("record_count", 64'(n_recv), 64'(n_pushed));
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_err_count"},   64'(bus.err_count),   64'(exp_flag(m_err_count)));
    check({tag, "_err_overrun"}, 64'(bus.err_overrun), 64'(exp_flag(m_err_overrun)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"},  64'(bus.out_valid),  64'd0);
    check({tag, "_out_last"},   64'(bus.out_last),   64'd0);
    check({tag, "_out_row"},    64'(bus.out_row),    64'd0);
    check({tag, "_out_column"}, 64'(bus.out_column), 64'd0);
    check({tag, "_out_rgb"},    64'(bus.out_rgb),    64'd0);
    check({tag, "_out_width"},  64'(bus.out_width),  64'd0);
    check({tag, "_err_count"},  64'(bus.err_count),  64'd0);
    check({tag, "_err_overrun"}, 64'(bus.err_overrun), 64'd0);
  endtask

  // Monitor: every valid cycle must match the queue head; pop on handshake
  initial begin : monitor
    rec_t got;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        got.row   = bus.out_row;
        got.col   = bus.out_column;
        got.rgb   = bus.out_rgb;
        got.width = bus.out_width;
        got.last  = bus.out_last;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_record actual row=%0d col=%0d rgb=%0h width=%0d last=%0d required=none",
                   got.row, got.col, got.rgb, got.width, got.last);
        end else begin
          if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL record actual row=%0d col=%0d rgb=%0h width=%0d last=%0d required row=%0d col=%0d rgb=%0h width=%0d last=%0d",
                     got.row, got.col, got.rgb, got.width, got.last,
                     exp_q[0].row, exp_q[0].col, exp_q[0].rgb, exp_q[0].width, exp_q[0].last);
          end
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            n_recv++;
          end
        end
      end
    end
  end

  // Consumer: always ready, random backpressure, or a 5-cycle stall at column 10
  initial begin : ready_driver
    bus.out_ready = 1'b1;
    forever begin
      tick();
      case (ready_mode)
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (!stall_done && bus.out_valid && (bus.out_column == COL_W'(10))) begin
            bus.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            stall_done = 1;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    bus.rgb  = '0;
    bus.oclk = 1'b0;
    bus.lat  = 1'b0;
    bus.oe   = 1'b0;
    bus.row  = '0;
    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Full line of 3'b101, 8-cycle pulse, free-flowing consumer
    ready_mode = 0;
    shift_line(COLS, 0, 1, 3'b101);
    pulse(3'd2, 8, 1);
    tick();
    check("oe_to_valid_1cyc", 64'(bus.out_valid), 64'd0);
    tick();
    check("oe_to_valid_2cyc", 64'(bus.out_valid), 64'd1);
    wait_drain(200);
    check_flags("full_line");

    // Short line (30 columns) raises the count error
    shift_line(30, 0, 0, '0);
    repeat (3) tick();
    check_flags("short_line");
    pulse(3'd5, 3, 1);
    wait_drain(200);

    // Backpressure held 5 cycles at column 10
    ready_mode = 2;
    shift_line(COLS, 0, 0, '0);
    pulse(3'd1, 5, 1);
    wait_drain(300);
    check("stall_applied", 64'(stall_done), 64'd1);
    ready_mode = 0;

    // Pulse during DRAIN is discarded and flagged; it outlasts the drain
    shift_line(COLS, 1, 0, '0);
    pulse(3'd3, 6, 1);
    wait_valid(50);
    repeat (3) tick();
    pulse(3'd7, 40, 0);
    m_err_overrun = 1;
    wait_drain(300);
    repeat (4) tick();
    check_flags("overrun");
    shift_line(COLS, 0, 0, '0);
    pulse(3'd4, 4, 1);
    wait_drain(300);

    // Randomized lines and pulses; next line shifts in while the previous drains
    ready_mode = 1;
    for (int it = 0; it < 12; it++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(26, 36)) : COLS;
      shift_line(n, $urandom_range(0, 1) == 1, 0, '0);
      wait_drain(1000);
      pulse(ROW_W'($urandom), int'($urandom_range(1, 40)), 1);
      wait_valid(50);
    end
    wait_drain(1000);
    repeat (3) tick();
    check_flags("random");

    // Width counter saturation
    ready_mode = 0;
    shift_line(COLS, 0, 0, '0);
    pulse(3'd6, 70000, 1);
    wait_drain(300);

    // Reset in the middle of a drain
    shift_line(COLS, 0, 0, '0);
    pulse(3'd2, 9, 1);
    begin
      bit found = 0;
      for (int i = 0; i < 200; i++) begin
        if (bus.out_valid && (bus.out_column == COL_W'(5))) begin
          found = 1;
          break;
        end
        tick();
      end
      check("reach_column5", 64'(found), 64'd1);
    end
    rst = 1'b1;
    tick();
    exp_q.delete();
    n_pushed = n_recv;
    model_reset();
    check_reset_outputs("midrain_reset");
    rst = 1'b0;
    tick();
    check("post_reset_valid", 64'(bus.out_valid), 64'd0);

    // Recovery after reset
    shift_line(COLS, 0, 0, '0);
    pulse(3'd1, 2, 1);
    wait_drain(300);
    check_flags("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
